idx_sram_ctrl: RTL and testbench

- Single-port arbiter and read sequencer in front of the encoder's index SRAM (byte-addressed, 64 KiB, 1-cycle read latency, 4-byte little-endian read word, byte write).
- Shares the SRAM between two requesters:
  - a byte-write requester (index producer);
  - a burst-read job (index consumer).
- Fetches aligned words and unpacks them into a valid/ready stream of signed 8-bit indices, one per cycle at full rate.

---
 rtl/idx_pkg.sv | 19 +
 rtl/idx_word_fifo.sv | 98 +++++++++
 rtl/idx_sram_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_idx_sram_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idx_pkg.sv
// Shared definitions for the index SRAM controller: widths, sequencer states
// and the byte-lane extraction used when unpacking fetched words.
package idx_pkg;

   localparam int ADDR_W = 16;
   localparam int WORD_W = 32;
   localparam int LEN_W  = 17;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   function automatic logic [7:0] lane_sel(input logic [WORD_W-1:0] word, input logic [1:0] lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/idx_word_fifo.sv
// Small word buffer between SRAM reads and the index stream. Each entry carries
// its own starting byte lane, remaining byte count and end-of-job flag.
module idx_word_fifo
   import idx_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [WORD_W-1:0] push_word,
   input  logic [1:0]        push_off,
   input  logic [2:0]        push_cnt,
   input  logic              push_last,
   input  logic              pop,
   output logic              head_valid,
   output logic [7:0]        head_data,
   output logic              head_last,
   output logic [CNT_W-1:0]  num
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WORD_W-1:0] word_q [DEPTH];
   logic [WORD_W-1:0] word_d [DEPTH];
   logic [1:0]        off_q  [DEPTH];
   logic [1:0]        off_d  [DEPTH];
   logic [2:0]        cnt_q  [DEPTH];
   logic [2:0]        cnt_d  [DEPTH];
   logic              last_q [DEPTH];
   logic              last_d [DEPTH];
   logic [PTR_W-1:0]  rd_q, rd_d;
   logic [PTR_W-1:0]  wr_q, wr_d;
   logic [CNT_W-1:0]  num_q, num_d;
   logic              pop_word;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign head_valid = (num_q != '0);
   assign head_data  = head_valid ? lane_sel(word_q[rd_q], off_q[rd_q]) : 8'h00;
   assign head_last  = head_valid && last_q[rd_q] && (cnt_q[rd_q] == 3'd1);
   assign num        = num_q;
   assign pop_word   = pop && head_valid && (cnt_q[rd_q] == 3'd1);

   always_comb begin
      word_d = word_q;
      off_d  = off_q;
      cnt_d  = cnt_q;
      last_d = last_q;
      rd_d   = rd_q;
      wr_d   = wr_q;
      num_d  = num_q;
      // A pop consumes one byte; the entry retires only with its final byte.
      if (pop && head_valid) begin
         if (pop_word) begin
            rd_d = ptr_inc(rd_q);
         end else begin
            off_d[rd_q] = off_q[rd_q] + 2'd1;
            cnt_d[rd_q] = cnt_q[rd_q] - 3'd1;
         end
      end
      if (push) begin
         word_d[wr_q] = push_word;
         off_d[wr_q]  = push_off;
         cnt_d[wr_q]  = push_cnt;
         last_d[wr_q] = push_last;
         wr_d         = ptr_inc(wr_q);
      end
      num_d = num_q + CNT_W'(push) - CNT_W'(pop_word);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            word_q[i] <= '0;
            off_q[i]  <= '0;
            cnt_q[i]  <= '0;
            last_q[i] <= 1'b0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         num_q <= '0;
      end else begin
         word_q <= word_d;
         off_q  <= off_d;
         cnt_q  <= cnt_d;
         last_q <= last_d;
         rd_q   <= rd_d;
         wr_q   <= wr_d;
         num_q  <= num_d;
      end
   end

endmodule

// File: rtl/idx_sram_ctrl.sv
// Index SRAM front end: arbitrates byte writes against burst word fetches and
// unpacks fetched words into a signed-byte stream.
//   state | meaning
//   IDLE  | no job; rd_start accepted, rd_len = 0 completes immediately
//   RUN   | word fetches outstanding for the job window
//   DRAIN | all words fetched; waiting for the last byte to handshake
module idx_sram_ctrl
   import idx_pkg::*;
#(
   parameter int BUF_DEPTH = 2
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              rd_start,
   input  logic [ADDR_W-1:0] rd_base,
   input  logic [LEN_W-1:0]  rd_len,
   output logic              rd_busy,
   output logic              rd_done,
   output logic              idx_valid,
   input  logic              idx_ready,
   output logic [7:0]        idx_data,
   output logic              idx_last,
   output logic              sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [WORD_W-1:0] sram_d,
   input  logic [WORD_W-1:0] sram_q
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   rd_state_e         state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0]  frem_q, frem_d;
   logic              infl_q, infl_d;
   logic [1:0]        infl_off_q, infl_off_d;
   logic [2:0]        infl_cnt_q, infl_cnt_d;
   logic              infl_last_q, infl_last_d;
   logic              last_wr_q, last_wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              done_q, done_d;
   logic              en_q;

   logic [CNT_W-1:0]  buf_num;
   logic [CNT_W:0]    occ;
   logic [ADDR_W-1:0] wr_off;
   logic              in_win;
   logic              wr_elig;
   logic              fetch_elig;
   logic              starve;
   logic              gnt_f;
   logic              gnt_w;
   logic [2:0]        avail;
   logic [2:0]        fetch_n;
   logic [LEN_W-1:0]  frem_nxt;
   logic              pop;

   assign wr_off  = wr_addr - base_q;
   assign in_win  = ({1'b0, wr_off} < len_q);
   // en_q keeps the write path quiet until the first clock after reset.
   assign wr_elig = en_q && wr_valid && !((state_q != IDLE) && in_win);

   assign occ        = {1'b0, buf_num} + (CNT_W+1)'(infl_q);
   assign fetch_elig = (state_q == RUN) && (frem_q != '0) && (occ < (CNT_W+1)'(BUF_DEPTH));
   assign starve     = (buf_num == '0) && !infl_q;

   assign gnt_f = fetch_elig && (!wr_elig || starve || last_wr_q);
   assign gnt_w = wr_elig && !gnt_f;

   assign avail    = 3'd4 - {1'b0, ptr_q[1:0]};
   assign fetch_n  = (frem_q < LEN_W'(avail)) ? frem_q[2:0] : avail;
   assign frem_nxt = frem_q - LEN_W'(fetch_n);

   assign wr_ready  = gnt_w;
   assign sram_wen  = gnt_w;
   assign sram_d    = gnt_w ? {{(WORD_W-8){wr_data[7]}}, wr_data} : '0;
   assign sram_addr = gnt_w ? wr_addr :
                      gnt_f ? {ptr_q[ADDR_W-1:2], 2'b00} : addr_q;
   assign addr_d    = sram_addr;

   assign rd_busy = (state_q != IDLE);
   assign rd_done = done_q;
   assign pop     = idx_valid && idx_ready;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      len_d       = len_q;
      ptr_d       = ptr_q;
      frem_d      = frem_q;
      done_d      = 1'b0;
      infl_d      = gnt_f;
      infl_off_d  = ptr_q[1:0];
      infl_cnt_d  = fetch_n;
      infl_last_d = (frem_nxt == '0);
      last_wr_d   = last_wr_q;
      if (gnt_w) begin
         last_wr_d = 1'b1;
      end else if (gnt_f) begin
         last_wr_d = 1'b0;
      end
      case (state_q)
         IDLE: begin
            if (rd_start) begin
               base_d = rd_base;
               len_d  = rd_len;
               ptr_d  = rd_base;
               frem_d = rd_len;
               if (rd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (gnt_f) begin
               ptr_d  = {ptr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
               frem_d = frem_nxt;
               if (frem_nxt == '0) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && idx_last) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         len_q       <= '0;
         ptr_q       <= '0;
         frem_q      <= '0;
         infl_q      <= 1'b0;
         infl_off_q  <= '0;
         infl_cnt_q  <= '0;
         infl_last_q <= 1'b0;
         last_wr_q   <= 1'b1;
         addr_q      <= '0;
         done_q      <= 1'b0;
         en_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         ptr_q       <= ptr_d;
         frem_q      <= frem_d;
         infl_q      <= infl_d;
         infl_off_q  <= infl_off_d;
         infl_cnt_q  <= infl_cnt_d;
         infl_last_q <= infl_last_d;
         last_wr_q   <= last_wr_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
         en_q        <= 1'b1;
      end
   end

   idx_word_fifo #(
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (infl_q),
      .push_word  (sram_q),
      .push_off   (infl_off_q),
      .push_cnt   (infl_cnt_q),
      .push_last  (infl_last_q),
      .pop        (pop),
      .head_valid (idx_valid),
      .head_data  (idx_data),
      .head_last  (idx_last),
      .num        (buf_num)
   );

endmodule

// File: tb/tb_idx_sram_ctrl.sv
// Bench for idx_sram_ctrl: SRAM model, byte-level reference memory and job
// model checked every cycle, plus directed timing and corner-case vectors.
module tb_idx_sram_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        rd_start;
   logic [15:0] rd_base;
   logic [16:0] rd_len;
   logic        rd_busy;
   logic        rd_done;
   logic        idx_valid;
   logic        idx_ready;
   logic [7:0]  idx_data;
   logic        idx_last;
   logic        sram_wen;
   logic [15:0] sram_addr;
   logic [31:0] sram_d;
   logic [31:0] sram_q;

   logic [7:0]  sram_mem [65536];
   logic [7:0]  ref_mem  [65536];

   int n_cmp = 0;
   int n_bad = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int bp_mode = 0;

   always #5 clk = ~clk;

   idx_sram_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_start  (rd_start),
      .rd_base   (rd_base),
      .rd_len    (rd_len),
      .rd_busy   (rd_busy),
      .rd_done   (rd_done),
      .idx_valid (idx_valid),
      .idx_ready (idx_ready),
      .idx_data  (idx_data),
      .idx_last  (idx_last),
      .sram_wen  (sram_wen),
      .sram_addr (sram_addr),
      .sram_d    (sram_d),
      .sram_q    (sram_q)
   );

   // SRAM: byte write, aligned 4-byte little-endian read with 1-cycle latency
   always @(posedge clk) begin
      if (sram_wen) begin
         sram_mem[sram_addr] <= sram_d[7:0];
      end else begin
         sram_q <= {sram_mem[{sram_addr[15:2], 2'b11}], sram_mem[{sram_addr[15:2], 2'b10}],
                    sram_mem[{sram_addr[15:2], 2'b01}], sram_mem[{sram_addr[15:2], 2'b00}]};
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Job model: expected byte queue taken from the reference memory at start.
   logic [7:0]  exp_q [$];
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic [15:0] m_base = '0;
   logic [16:0] m_len = '0;
   logic        pv_stall = 1'b0;
   logic [7:0]  pv_data = '0;
   logic        pv_last = 1'b0;

   always @(negedge clk) begin
      logic        nb;
      logic        nd;
      logic [15:0] woff;
      if (!rst_n) begin
         exp_q.delete();
         m_busy   = 1'b0;
         m_done   = 1'b0;
         pv_stall = 1'b0;
      end else begin
         check("rd_busy", {31'b0, rd_busy}, {31'b0, m_busy});
         check("rd_done", {31'b0, rd_done}, {31'b0, m_done});
         if (rd_done) done_cnt++;
         woff = wr_addr - m_base;
         if (m_busy && wr_valid && ({1'b0, woff} < m_len))
            check("coherence_hold", {31'b0, wr_ready}, 32'd0);
         if (!wr_valid)
            check("wr_ready_idle", {31'b0, wr_ready}, 32'd0);
         if (wr_valid && wr_ready) begin
            check("wr_wen", {31'b0, sram_wen}, 32'd1);
            check("wr_addr", {16'b0, sram_addr}, {16'b0, wr_addr});
            check("wr_sext", sram_d, {{24{wr_data[7]}}, wr_data});
            ref_mem[wr_addr] = wr_data;
         end else begin
            check("no_wen", {31'b0, sram_wen}, 32'd0);
         end
         if (pv_stall) begin
            check("stall_valid", {31'b0, idx_valid}, 32'd1);
            check("stall_data", {24'b0, idx_data}, {24'b0, pv_data});
            check("stall_last", {31'b0, idx_last}, {31'b0, pv_last});
         end
         nb = m_busy;
         nd = 1'b0;
         if (idx_valid) begin
            if (exp_q.size() == 0) begin
               check("stale_byte", {31'b0, idx_valid}, 32'd0);
            end else begin
               check("idx_data", {24'b0, idx_data}, {24'b0, exp_q[0]});
               check("idx_last", {31'b0, idx_last}, (exp_q.size() == 1) ? 32'd1 : 32'd0);
               if (idx_ready) begin
                  hs_cnt++;
                  void'(exp_q.pop_front());
                  if (exp_q.size() == 0) begin
                     nb = 1'b0;
                     nd = 1'b1;
                  end
               end
            end
         end
         pv_stall = idx_valid && !idx_ready;
         pv_data  = idx_data;
         pv_last  = idx_last;
         if (!m_busy && rd_start) begin
            if (rd_len == 17'd0) begin
               nd = 1'b1;
            end else begin
               nb     = 1'b1;
               m_base = rd_base;
               m_len  = rd_len;
               for (int i = 0; i < int'(rd_len); i++)
                  exp_q.push_back(ref_mem[16'(int'(rd_base) + i)]);
            end
         end
         m_busy = nb;
         m_done = nd;
      end
   end

   initial begin
      idx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (bp_mode)
            0:       idx_ready = 1'b1;
            1:       idx_ready = 1'($urandom_range(0, 1));
            default: idx_ready = 1'b0;
         endcase
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [15:0] base, input logic [16:0] len);
      rd_start = 1'b1;
      rd_base  = base;
      rd_len   = len;
      tick();
      rd_start = 1'b0;
   endtask

   task automatic wait_done(input string nm, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (rd_done) seen = 1'b1;
      end
      check(nm, {31'b0, seen}, 32'd1);
      tick();
   endtask

   task automatic wait_valid(input string nm, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (idx_valid) seen = 1'b1;
      end
      check(nm, {31'b0, seen}, 32'd1);
   endtask

   task automatic aligned_burst(input string tag);
      start_job(16'h0010, 17'd8);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check({tag, "_addr0"}, {16'b0, sram_addr}, 32'h0010);
            check({tag, "_busy"}, {31'b0, rd_busy}, 32'd1);
         end
         if (c == 2) begin
            check({tag, "_addr1"}, {16'b0, sram_addr}, 32'h0014);
            check({tag, "_early"}, {31'b0, idx_valid}, 32'd0);
         end
         if (c >= 3 && c <= 10) begin
            check({tag, "_valid"}, {31'b0, idx_valid}, 32'd1);
            check({tag, "_byte"}, {24'b0, idx_data}, 32'(c - 2));
            check({tag, "_last"}, {31'b0, idx_last}, (c == 10) ? 32'd1 : 32'd0);
         end
         if (c == 11) begin
            check({tag, "_done"}, {31'b0, rd_done}, 32'd1);
            check({tag, "_idle"}, {31'b0, rd_busy}, 32'd0);
         end
      end
      tick();
   endtask

   initial begin
      int  hs0;
      int  d0;
      int  nw;
      int  nf;
      bit  prev_f;
      bit  cur_f;
      bit  fin;
      bit  acc;
      bit  seen_done;
      bit  bad;
      logic wr_seen;

      for (int a = 0; a < 65536; a++) begin
         sram_mem[a] = 8'(a * 7 + (a >> 8) * 13 + 1);
         ref_mem[a]  = 8'(a * 7 + (a >> 8) * 13 + 1);
      end
      for (int a = 0; a < 8; a++) begin
         sram_mem[16 + a] = 8'(a + 1);
         ref_mem[16 + a]  = 8'(a + 1);
      end
      sram_mem[16'hFFFE] = 8'hA1; ref_mem[16'hFFFE] = 8'hA1;
      sram_mem[16'hFFFF] = 8'hA2; ref_mem[16'hFFFF] = 8'hA2;
      sram_mem[16'h0000] = 8'hA3; ref_mem[16'h0000] = 8'hA3;
      sram_mem[16'h0001] = 8'hA4; ref_mem[16'h0001] = 8'hA4;
      sram_q   = '0;
      rst_n    = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      rd_start = 1'b0;
      rd_base  = '0;
      rd_len   = '0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'b0, rd_busy}, 32'd0);
      check("rst_valid", {31'b0, idx_valid}, 32'd0);
      check("rst_wen", {31'b0, sram_wen}, 32'd0);
      check("rst_addr", {16'b0, sram_addr}, 32'd0);
      check("rst_done", {31'b0, rd_done}, 32'd0);
      rst_n = 1'b1;
      tick();
      tick();

      aligned_burst("burst");

      start_job(16'hFFFE, 17'd4);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) check("wrap_addr0", {16'b0, sram_addr}, 32'hFFFC);
         if (c == 2) check("wrap_addr1", {16'b0, sram_addr}, 32'h0000);
         if (c == 3) check("wrap_b0", {24'b0, idx_data}, 32'hA1);
         if (c == 4) check("wrap_b1", {24'b0, idx_data}, 32'hA2);
         if (c == 5) check("wrap_b2", {24'b0, idx_data}, 32'hA3);
         if (c == 6) begin
            check("wrap_b3", {24'b0, idx_data}, 32'hA4);
            check("wrap_last", {31'b0, idx_last}, 32'd1);
         end
      end
      wait_done("wrap_done", 10);

      start_job(16'h0040, 17'd0);
      @(negedge clk);
      check("len0_done", {31'b0, rd_done}, 32'd1);
      check("len0_busy", {31'b0, rd_busy}, 32'd0);
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (idx_valid) bad = 1'b1;
      end
      check("len0_no_valid", {31'b0, bad}, 32'd0);
      tick();

      bp_mode = 1;
      hs0 = hs_cnt;
      start_job(16'h0123, 17'd37);
      wait_done("bp_done", 500);
      check("bp_count", 32'(hs_cnt - hs0), 32'd37);
      bp_mode = 0;
      tick();

      hs0 = hs_cnt;
      d0  = done_cnt;
      start_job(16'h0010, 17'd8);
      rd_start = 1'b1;
      rd_base  = 16'h0200;
      rd_len   = 17'd4;
      tick();
      rd_start = 1'b0;
      wait_done("busy_start_done", 30);
      repeat (8) tick();
      check("busy_start_bytes", 32'(hs_cnt - hs0), 32'd8);
      check("busy_start_dones", 32'(done_cnt - d0), 32'd1);

      // Contention: out-of-window writer held busy through a 16-byte job
      hs0 = hs_cnt;
      nw = 0; nf = 0; prev_f = 1'b0; fin = 1'b0;
      rd_start = 1'b1; rd_base = 16'h0020; rd_len = 17'd16;
      wr_valid = 1'b1; wr_addr = 16'h8000; wr_data = 8'h40;
      for (int c = 0; c < 300 && !fin; c++) begin
         @(negedge clk);
         wr_seen = wr_ready;
         cur_f = rd_busy && !wr_ready;
         if (cur_f) begin
            check("cont_fetch_addr", {16'b0, sram_addr}, 32'(32'h20 + 4 * nf));
            check("cont_alternate", {31'b0, prev_f}, 32'd0);
            nf++;
         end
         if (wr_seen) nw++;
         if (rd_done) fin = 1'b1;
         prev_f = cur_f;
         tick();
         rd_start = 1'b0;
         if (wr_seen) begin
            wr_addr = wr_addr + 16'd1;
            wr_data = wr_data + 8'd1;
         end
      end
      wr_valid = 1'b0;
      check("cont_done", {31'b0, fin}, 32'd1);
      check("cont_fetches", 32'(nf), 32'd4);
      check("cont_bytes", 32'(hs_cnt - hs0), 32'd16);
      tick();
      hs0 = hs_cnt;
      start_job(16'h8000, 17'(nw));
      wait_done("cont_readback_done", 100);
      check("cont_readback_bytes", 32'(hs_cnt - hs0), 32'(nw));

      // Coherence: in-window write held until the job ends
      bp_mode = 2;
      tick();
      start_job(16'h0100, 17'd32);
      wr_valid = 1'b1; wr_addr = 16'h0105; wr_data = 8'hFB;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("coh_stalled", {31'b0, wr_ready}, 32'd0);
      end
      bp_mode = 0;
      acc = 1'b0; seen_done = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
         @(negedge clk);
         if (rd_done) seen_done = 1'b1;
         if (wr_ready) begin
            acc = 1'b1;
            check("coh_after_done", {31'b0, seen_done}, 32'd1);
            check("coh_sext", sram_d, 32'hFFFF_FFFB);
         end
      end
      check("coh_accepted", {31'b0, acc}, 32'd1);
      tick();
      wr_valid = 1'b0;
      start_job(16'h0105, 17'd1);
      wait_valid("coh_rb_valid", 10);
      check("coh_readback", {24'b0, idx_data}, 32'hFB);
      wait_done("coh_rb_done", 10);

      // Reset in the middle of a job
      start_job(16'h0300, 17'd37);
      wait_valid("rst_mid_valid", 10);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", {31'b0, idx_valid}, 32'd0);
      check("mid_rst_data", {24'b0, idx_data}, 32'd0);
      check("mid_rst_last", {31'b0, idx_last}, 32'd0);
      check("mid_rst_busy", {31'b0, rd_busy}, 32'd0);
      check("mid_rst_done", {31'b0, rd_done}, 32'd0);
      check("mid_rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      check("mid_rst_wen", {31'b0, sram_wen}, 32'd0);
      check("mid_rst_addr", {16'b0, sram_addr}, 32'd0);
      check("mid_rst_d", sram_d, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (idx_valid || rd_done) bad = 1'b1;
      end
      check("post_rst_quiet", {31'b0, bad}, 32'd0);
      tick();
      aligned_burst("post_rst");

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
